// File: rtl/d16i_irq_pkg.sv
// Shared types and helpers for the interrupt controller: FSM state encoding,
// ID word width, default tag and the ID word builder.
package d16i_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    LOAD    = 2'd2,
    SERVICE = 2'd3
  } irq_state_t;

  localparam int IRQ_BUS_W = 17;
  localparam logic [7:0] ID_TAG_DEFAULT = 8'h80;

  // ID word layout: [16] reserved zero, [15:8] tag, [7:0] line index.
  function automatic logic [IRQ_BUS_W-1:0] build_id(input logic [7:0] tag,
                                                    input logic [7:0] idx);
    return {1'b0, tag, idx};
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational fixed-priority encoder: the lowest set index of req_i wins.
module irq_prio_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  // Scan from the top down so the last hit, the lowest index, sticks.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IDX_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Edge-capturing, maskable, fixed-priority interrupt controller with a
// req/ack handshake to the core. Optional input synchronizer: IRQ_SYNC_EN.
module irq_ctrl
  import d16i_irq_pkg::*;
#(
  parameter int         N_IRQ  = 8,
  parameter logic [7:0] ID_TAG = ID_TAG_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_IRQ-1:0]     irq_in,
  input  logic                 mask_we,
  input  logic [N_IRQ-1:0]     mask_wdata,
  output logic [N_IRQ-1:0]     mask_q,
  output logic [N_IRQ-1:0]     pending_q,
  output logic                 irq_req,
  input  logic                 irq_ack,
  input  logic                 irq_eoi,
  output logic                 irq_sel,
  output logic [IRQ_BUS_W-1:0] irq_bus,
  output logic                 busy,
  output irq_state_t           state_o
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  // Handshake: irq_req stays high in REQ until the core samples irq_ack high
  // on a clock edge while an eligible line exists; that edge is the transfer.
  irq_state_t           state_q, state_d;
  logic [N_IRQ-1:0]     irq_s, irq_prev_q, rise, elig, win_onehot, pending_d;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_vld;
  logic [IRQ_BUS_W-1:0] bus_d;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign rise       = irq_s & ~irq_prev_q;
  assign elig       = pending_q & mask_q;
  assign win_onehot = N_IRQ'(1) << win_idx;
  assign state_o    = state_q;

  irq_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_prio (
    .req_i   (elig),
    .idx_o   (win_idx),
    .valid_o (win_vld)
  );

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | rise;
    bus_d     = irq_bus;
    case (state_q)
      IDLE:    if (win_vld) state_d = REQ;
      REQ: begin
        if (irq_ack && win_vld) begin
          state_d   = LOAD;
          // A fresh edge on the serviced line re-arms it.
          pending_d = (pending_q & ~win_onehot) | rise;
          bus_d     = build_id(ID_TAG, 8'(win_idx));
        end else if (!win_vld) begin
          state_d = IDLE;
        end
      end
      LOAD:    state_d = SERVICE;
      SERVICE: if (irq_eoi) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      irq_prev_q <= '0;
      pending_q  <= '0;
      mask_q     <= '0;
      irq_bus    <= '0;
      irq_req    <= 1'b0;
      irq_sel    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_prev_q <= irq_s;
      pending_q  <= pending_d;
      if (mask_we) mask_q <= mask_wdata;
      irq_bus    <= bus_d;
      irq_req    <= (state_d == REQ);
      irq_sel    <= (state_d == LOAD);
      busy       <= (state_d == LOAD) || (state_d == SERVICE);
    end
  end

endmodule
